// File: rtl/weight_buffer.sv
// Weight store for the systolic array: streamed loads, multi-lane
// registered reads and a sequenced clear sweep.
module weight_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int LANES  = 4,
   parameter int WRAP   = 1,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_start,
   input  logic [ADDR_W-1:0]       load_base,
   input  logic                    load_valid,
   input  logic [DATA_W-1:0]       load_data,
   output logic                    load_ready,
   input  logic                    clear,
   output logic                    busy,
   input  logic                    rd_en,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic                    rd_valid,
   output logic [LANES*DATA_W-1:0] rd_data
);

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   SPAN = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0]       mem [DEPTH];
   state_t                  state;
   state_t                  state_nxt;
   logic [ADDR_W-1:0]       wptr;
   logic [ADDR_W-1:0]       clr_ptr;
   logic [ADDR_W-1:0]       wr_addr;
   logic [ADDR_W-1:0]       wr_nxt;
   logic                    wr_en;
   logic                    clr_last;
   logic                    clr_go;
   logic                    rd_go;
   logic [LANES*DATA_W-1:0] lanes;

   assign busy       = (state == CLEAR);
   assign load_ready = !busy && !clear;
   assign wr_en      = load_valid && load_ready;
   assign wr_addr    = load_start ? load_base : wptr;
   assign wr_nxt     = (wr_addr == LAST) ? '0 : wr_addr + 1'b1;
   assign clr_last   = (clr_ptr == LAST);
   assign rd_go      = rd_en && !busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      clr_go    = 1'b0;
      unique case (state)
         IDLE: begin
            if (clear) begin
               state_nxt = CLEAR;
               clr_go    = 1'b1;
            end
         end
         CLEAR: begin
            if (clr_last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clr_ptr <= '0;
      end else if (clr_go) begin
         clr_ptr <= '0;
      end else if (busy) begin
         clr_ptr <= clr_last ? '0 : clr_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
      end else if (wr_en) begin
         wptr <= wr_nxt;
      end else if (load_start && load_ready) begin
         wptr <= load_base;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (busy) begin
         mem[clr_ptr] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= load_data;
      end
   end

   // Lanes past the end either wrap or read zero; a base past the end reads all zero.
   always_comb begin
      lanes = '0;
      if ({1'b0, rd_addr} < SPAN) begin
         for (int k = 0; k < LANES; k++) begin
            logic [ADDR_W:0] sum;
            sum = {1'b0, rd_addr} + (ADDR_W + 1)'(k);
            if (sum < SPAN) begin
               lanes[k*DATA_W +: DATA_W] = mem[sum[ADDR_W-1:0]];
            end else if (WRAP != 0) begin
               sum = sum - SPAN;
               lanes[k*DATA_W +: DATA_W] = mem[sum[ADDR_W-1:0]];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_go;
         if (rd_go) begin
            rd_data <= lanes;
         end
      end
   end

endmodule
